// File: rtl/cms_pix28_pkg.sv
// cms_pix28_pkg
// Shared definitions for the pixel-configuration shift sequencer:
//   - state encodings of the serialiser FSM
//   - default configuration word length and divider width
package cms_pix28_pkg;

  localparam int CFG_BITS_DEFAULT = 768;
  localparam int DIV_W_DEFAULT    = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_TAIL     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SHIFT_LO = ST_SHIFT_LO,
    SHIFT_HI = ST_SHIFT_HI,
    GAP      = ST_GAP,
    LOAD     = ST_LOAD,
    TAIL     = ST_TAIL
  } cms_state_t;

endpackage

// File: rtl/cfg_halfper_timer.sv
// cfg_halfper_timer
// Phase timer for the config serialiser. A load strobe starts a phase of
// half_i cycles; tick_o is high on the last cycle of that phase.
// Ports:
//   pl_clk1  in   clock
//   reset    in   synchronous active-high reset
//   load_i   in   start a new phase on the next cycle
//   half_i   in   phase length in cycles (caller guarantees >= 1)
//   tick_o   out  high while the current phase is on its last cycle
module cfg_halfper_timer #(
  parameter int DIV_W = 8
) (
  input  logic             pl_clk1,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count;

  // Count down from half_i-1 to 0. Reloading every phase means the
  // maximum divider value never has to wrap through zero.
  always_ff @(posedge pl_clk1) begin
    if (reset) begin
      count <= '0;
    end else if (load_i) begin
      count <= half_i - DIV_W'(1);
    end else if (count != '0) begin
      count <= count - DIV_W'(1);
    end
  end

  assign tick_o = (count == '0);

endmodule

// File: rtl/config_shift_sequencer.sv
// config_shift_sequencer
// Serialises one configuration word MSB first as a config_clk / config_in /
// config_load waveform. Every output comes straight from a flop so the
// downstream ODDR stage sees clean, registered launches.
// Ports:
//   pl_clk1        in   sole clock
//   reset          in   synchronous active-high reset
//   start_i        in   begin a transfer (ignored while busy)
//   abort_i        in   cancel a transfer in progress
//   cfg_word_i     in   word captured on the accepted start cycle
//   clk_div_i      in   half period in pl_clk1 cycles, 0 behaves as 1
//   config_clk_o   out  serial clock
//   config_in_o    out  serial data
//   config_load_o  out  latch pulse after the last bit
//   busy_o         out  transfer in progress
//   done_o         out  one-cycle pulse on normal completion
module config_shift_sequencer
  import cms_pix28_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEFAULT,
  parameter int DIV_W    = DIV_W_DEFAULT
) (
  input  logic                pl_clk1,
  input  logic                reset,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [CFG_BITS-1:0] cfg_word_i,
  input  logic [DIV_W-1:0]    clk_div_i,
  output logic                config_clk_o,
  output logic                config_in_o,
  output logic                config_load_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BITS - 1);

  cms_state_t          state;
  logic [CFG_BITS-1:0] shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    half_q;
  logic                load_second;

  logic [DIV_W-1:0]    half_start;
  logic [DIV_W-1:0]    timer_half;
  logic                timer_load;
  logic                tick;

  // In IDLE the timer is primed with the divider presented alongside
  // start; afterwards it only ever sees the captured value, so divider
  // changes mid-transfer are invisible.
  assign half_start = (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
  assign timer_half = (state == IDLE) ? half_start : half_q;
  assign timer_load = (state == IDLE) ? start_i : tick;

  cfg_halfper_timer #(.DIV_W(DIV_W)) u_timer (
    .pl_clk1 (pl_clk1),
    .reset   (reset),
    .load_i  (timer_load),
    .half_i  (timer_half),
    .tick_o  (tick)
  );

  // Main sequencer: outputs are assigned together with the state they
  // belong to, so each output flop already holds the value of the phase
  // being entered. LOAD spans two timer phases, tracked by load_second.
  always_ff @(posedge pl_clk1) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      half_q        <= '0;
      load_second   <= 1'b0;
      config_clk_o  <= 1'b0;
      config_in_o   <= 1'b0;
      config_load_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i) begin
          state        <= SHIFT_LO;
          shreg        <= cfg_word_i;
          bit_cnt      <= LAST_IDX;
          half_q       <= half_start;
          load_second  <= 1'b0;
          config_clk_o <= 1'b0;
          config_in_o  <= cfg_word_i[CFG_BITS-1];
          busy_o       <= 1'b1;
        end
      end else if (abort_i) begin
        state         <= IDLE;
        shreg         <= '0;
        bit_cnt       <= '0;
        load_second   <= 1'b0;
        config_clk_o  <= 1'b0;
        config_in_o   <= 1'b0;
        config_load_o <= 1'b0;
        busy_o        <= 1'b0;
      end else if (tick) begin
        case (state)
          SHIFT_LO: begin
            state        <= SHIFT_HI;
            config_clk_o <= 1'b1;
          end
          SHIFT_HI: begin
            config_clk_o <= 1'b0;
            if (bit_cnt != '0) begin
              state       <= SHIFT_LO;
              shreg       <= shreg << 1;
              bit_cnt     <= bit_cnt - CNT_W'(1);
              config_in_o <= shreg[CFG_BITS-2];
            end else begin
              state       <= GAP;
              config_in_o <= 1'b0;
            end
          end
          GAP: begin
            state         <= LOAD;
            load_second   <= 1'b0;
            config_load_o <= 1'b1;
          end
          LOAD: begin
            if (!load_second) begin
              load_second <= 1'b1;
            end else begin
              state         <= TAIL;
              load_second   <= 1'b0;
              config_load_o <= 1'b0;
            end
          end
          TAIL: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
          default: begin
            state         <= IDLE;
            config_clk_o  <= 1'b0;
            config_in_o   <= 1'b0;
            config_load_o <= 1'b0;
            busy_o        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
